// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} entries fed by a
// sequential fetch PC, flushed by redirect. `FETCHQ_BYPASS_EN adds an empty-queue bypass.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [PC_W-1:0]            mem_addr,
  input  logic [31:0]                mem_rdata,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a head entry moves to decode when out_valid && out_ready at posedge;
  // out_valid never depends on out_ready, and a word is fetched whenever mem_req=1.

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [PC_W-1:0] fpc;
  logic            empty, full;
  logic            pop, push_st, pop_st;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign mem_addr = fpc;

  // A non-empty queue pops exactly when out_ready is high, so the pop term is
  // expressed directly from out_ready to keep mem_req free of a loop through out_valid.
  assign mem_req = ~rst & ~redirect & (~full | (out_ready & ~empty));

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass = empty & mem_req;
`endif

  always_comb begin
    out_valid = ~rst & ~empty;
    out_instr = instr_mem[rd_ptr];
    out_pc    = pc_mem[rd_ptr];
`ifdef FETCHQ_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = mem_rdata;
      out_pc    = fpc;
    end
`endif
    if (!out_valid) begin
      out_instr = '0;
      out_pc    = '0;
    end
  end

  assign pop = out_valid & out_ready;

`ifdef FETCHQ_BYPASS_EN
  // A bypassed word taken by decode never enters storage.
  assign push_st = mem_req & ~(bypass & out_ready);
  assign pop_st  = pop & ~bypass;
`else
  assign push_st = mem_req;
  assign pop_st  = pop;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fpc    <= PC_W'(RESET_PC);
    end else if (redirect) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fpc    <= redirect_pc & ~PC_W'(3);
    end else begin
      if (mem_req) fpc    <= fpc + PC_W'(4);
      if (push_st) wr_ptr <= wr_ptr + AW'(1);
      if (pop_st)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_st, pop_st})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_st) begin
      pc_mem[wr_ptr]    <= fpc;
      instr_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 DEPTH, 4, queue entries; power of two, 2..16.
- REQ-002 PC_W, 8, instruction byte-address width.
- REQ-003 RESET_PC, 0, first fetch address after reset; word aligned.
- REQ-004 clk  input  1  single clock; all state updates on posedge clk.
- REQ-005 rst  input  1  reset; synchronous, active-high.
- REQ-006 mem_req  output  1  fetch request to unified memory instruction port.
- REQ-007 mem_addr  output  PC_W  fetch byte address; equals internal fetch PC.
- REQ-008 mem_rdata  input  32  instruction word; valid in the same cycle as mem_req.
- REQ-009 redirect  input  1  branch/jump flush request.
- REQ-010 redirect_pc  input  PC_W  new fetch address when redirect=1.
- REQ-011 out_valid  output  1  head entry available to decode.
- REQ-012 out_ready  input  1  decode accepts head this cycle.
- REQ-013 out_instr  output  32  head instruction word.
- REQ-014 out_pc  output  PC_W  head instruction address.
- REQ-015 count  output  $clog2(DEPTH+1)  occupied entries.

Function
- REQ-016 Storage: circular buffer of DEPTH {pc, instr} entries; write/read pointers wrap modulo DEPTH.
- REQ-017 pop = out_valid & out_ready; push = mem_req.
- REQ-018 mem_req = ~rst & ~redirect & ((count < DEPTH) | pop).
- REQ-019 On push: store {fpc, mem_rdata} at write pointer; fpc <= fpc + 4, wrapping modulo 2^PC_W.
- REQ-020 Push and pop in the same cycle: count unchanged; both pointers advance.
- REQ-021 Full (count = DEPTH) with no pop: mem_req=0; fpc and contents hold.
- REQ-022 Empty (count = 0): out_valid=0; a pop is impossible.
- REQ-023 Latency: word pushed in cycle N appears at head no earlier than cycle N+1; FIFO order preserved.
- REQ-024 out_instr and out_pc are 0 whenever out_valid=0.
- REQ-025 Redirect: the head pop in the redirect cycle is a valid handshake. Next cycle: count=0, both pointers=0, fpc = {redirect_pc[PC_W-1:2], 2'b00}. No push in the redirect cycle.
- REQ-026 redirect held for several cycles: each cycle re-flushes and reloads fpc from redirect_pc; fetch resumes in the cycle after redirect deasserts.

Reset
- REQ-027 When rst=1 at posedge: count=0, pointers=0, fpc=RESET_PC.
- REQ-028 While rst=1: out_valid=0, out_instr=0, out_pc=0, mem_req=0; mem_addr=fpc.
- REQ-029 rst overrides redirect, push and pop in the same cycle.
- REQ-030 Entry storage is not reset.

Configuration
- REQ-031 Macro FETCHQ_BYPASS_EN enables a zero-latency bypass.
- REQ-032 Bypass defined: when count=0 and mem_req=1, out_valid=1, out_instr=mem_rdata, out_pc=fpc in the same cycle. If out_ready=1, the word is consumed and not stored (count stays 0); otherwise it is stored normally.
- REQ-033 Bypass is never active in a redirect or reset cycle.
- REQ-034 Without the macro, REQ-023 latency applies and no combinational path exists from mem_rdata to out_*.

Verification
- REQ-035 Reset release, out_ready=1, mem_rdata=0x00000013 -> mem_addr 0,4,8,... per cycle. out_pc lags mem_addr by 1 cycle without bypass, 0 cycles with bypass.
- REQ-036 out_ready=0 for 6 cycles, DEPTH=4 -> count 1,2,3,4,4,4. mem_req drops after the 4th push. fpc holds at 0x10. Draining returns pcs 0,4,8,C in order.
- REQ-037 Full queue, out_ready=1 for one cycle -> simultaneous push/pop. count stays 4. Head becomes pc 4. Tail gets pc 0x10.
- REQ-038 count=3, redirect=1, redirect_pc=0x47, out_ready=1 -> head pc accepted that cycle. Next cycle: count=0, mem_addr=0x44, out_valid=0 (1 with bypass).
- REQ-039 fpc=0xFC, push -> next mem_addr=0x00 (wrap). Stored out_pc=0xFC.
- REQ-040 rst asserted with count=2 and redirect=1 -> next cycle: count=0, mem_addr=RESET_PC, out_valid=0, out_instr=0.
